// File: rtl/fpmul_pkg.sv
// Shared types and constants for the iterative FP multiplier.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fpmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MULT,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } op_class_e;

  // Exponent bias for a given exponent width.
  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Unsigned infinity pattern: exponent all ones, fraction zero.
  function automatic logic [63:0] inf_mag(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    return inf_mag(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_multiplier_iter_if.sv
// Start/busy/done request bus between the controller and the FP multiplier.
// Latency: n/a (wiring only).
// Backpressure: controller must wait for done before issuing again; start is ignored while busy.
interface fp_multiplier_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] product_o;
  logic         nan_o;
  logic         inf_o;
  logic         overflow_o;
  logic         underflow_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, product_o, nan_o, inf_o, overflow_o, underflow_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, product_o, nan_o, inf_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fpmul_sig_iter.sv
// Iterative shift-add significand multiplier, BITS_PER_CYC multiplier bits per step.
// Latency: one load cycle then M/BITS_PER_CYC step cycles; product valid after the last step.
// Backpressure: none; fully sequenced by the parent FSM through load/step.
module fpmul_sig_iter #(
  parameter int M            = 24,
  parameter int BITS_PER_CYC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [M-1:0]   mcand,
  input  logic [M-1:0]   mplier,
  input  logic           step,
  output logic [2*M-1:0] product
);

  logic [2*M-1:0] mcand_q;
  logic [M-1:0]   mplier_q;
  logic [2*M-1:0] acc_q;
  logic [2*M-1:0] partial;

  // Partial product for the low BITS_PER_CYC multiplier bits against the shifted multiplicand.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  // Load clears the accumulator; each step adds one partial product and advances both shifters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{M{1'b0}}, mcand};
      mplier_q <= mplier;
      acc_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_q + partial;
      mcand_q  <= mcand_q << BITS_PER_CYC;
      mplier_q <= mplier_q >> BITS_PER_CYC;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/fp_multiplier_iter.sv
// Iterative IEEE-754-style FP multiplier with NaN/Inf/overflow/underflow flags; FPMUL_RNE_EN selects RNE, else truncation.
// Latency: (MAN_W+1)/BITS_PER_CYC+3 edges for finite operands, 1 edge for special operands.
// Backpressure: one operation at a time; start is only sampled in IDLE, busy high otherwise.
module fp_multiplier_iter
  import fpmul_pkg::*;
#(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int BITS_PER_CYC = 1
) (
  input logic              clk,
  input logic              rst_n,
  fp_multiplier_iter_if.slave bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int M     = MAN_W + 1;
  localparam int N     = M / BITS_PER_CYC;
  localparam int CNT_W = $clog2(N + 1);
  localparam int EW    = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS_E  = EW'(bias_of(EXP_W));
  localparam logic signed [EW-1:0] E_MAX   = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO  = '0;
  localparam logic signed [EW-1:0] E_ONE   = EW'(1);
  localparam logic [W-1:0]         QNAN    = W'(qnan_word(EXP_W, MAN_W));
  localparam logic [W-1:0]         INF_MAG = W'(inf_mag(EXP_W, MAN_W));

  function automatic op_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (&e)           return (|f) ? CLS_NAN : CLS_INF;
    else if (e == '0) return CLS_ZERO;
    else              return CLS_NORMAL;
  endfunction

  state_e state_q, state_d;

  logic [W-1:0]           a_q, b_q;
  logic                   sign_q;
  logic signed [EW-1:0]   e_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [M-1:0]           sig_q;
  logic                   guard_q, sticky_q;
  logic [W-1:0]           product_q;
  logic                   nan_q, inf_q, ovf_q, unf_q;

  logic [2*M-1:0]         prod;
  logic                   accept;
  op_class_e              cls_a, cls_b;
  logic                   res_sign;
  logic                   spec_hit, spec_nan, spec_inf;
  logic [W-1:0]           spec_prod;
  logic [2*M-1:0]         norm_v;
  logic                   lost_v;
  logic [MAN_W-1:0]       rnd_frac;
  logic signed [EW-1:0]   rnd_e;
  logic                   unused_norm;

  assign accept   = (state_q == S_IDLE) && bus.start_i;
  assign cls_a    = classify(a_q[W-2:MAN_W], a_q[MAN_W-1:0]);
  assign cls_b    = classify(b_q[W-2:MAN_W], b_q[MAN_W-1:0]);
  assign res_sign = a_q[W-1] ^ b_q[W-1];

  fpmul_sig_iter #(
    .M            (M),
    .BITS_PER_CYC (BITS_PER_CYC)
  ) u_sig (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == S_UNPACK),
    .mcand   ({1'b1, a_q[MAN_W-1:0]}),
    .mplier  ({1'b1, b_q[MAN_W-1:0]}),
    .step    (state_q == S_MULT),
    .product (prod)
  );

  // Special-operand routing: NaN and Inf x Zero give qNaN, Inf gives signed Inf, Zero gives signed zero.
  always_comb begin
    spec_hit  = 1'b1;
    spec_nan  = 1'b0;
    spec_inf  = 1'b0;
    spec_prod = '0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) || (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      spec_prod = QNAN;
      spec_nan  = 1'b1;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      spec_prod = {res_sign, INF_MAG[W-2:0]};
      spec_inf  = 1'b1;
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      spec_prod = {res_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit  = 1'b0;
    end
  end

  // Normalise the raw product so the leading one sits at bit 2M-2; a bit shifted out feeds sticky.
  always_comb begin
    norm_v = prod;
    lost_v = 1'b0;
    if (prod[2*M-1]) begin
      norm_v = {1'b0, prod[2*M-1:1]};
      lost_v = prod[0];
    end
  end
  assign unused_norm = norm_v[2*M-1];

`ifdef FPMUL_RNE_EN
  logic         rnd_inc;
  logic [M:0]   rnd_sum;

  // Round to nearest even; a carry out of the significand renormalises by one place.
  always_comb begin
    rnd_inc  = guard_q & (sticky_q | sig_q[0]);
    rnd_sum  = {1'b0, sig_q} + {{M{1'b0}}, rnd_inc};
    rnd_frac = rnd_sum[MAN_W-1:0];
    rnd_e    = e_q;
    if (rnd_sum[M]) begin
      rnd_frac = rnd_sum[MAN_W:1];
      rnd_e    = e_q + E_ONE;
    end
  end
`else
  logic unused_round;

  // Truncation: the stored fraction is used as-is, guard and sticky are dropped.
  always_comb begin
    rnd_frac = sig_q[MAN_W-1:0];
    rnd_e    = e_q;
  end
  assign unused_round = ^{guard_q, sticky_q, sig_q[MAN_W]};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing through unpack, multiply, normalise, round and done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start_i) state_d = S_UNPACK;
      S_UNPACK: state_d = spec_hit ? S_DONE : S_MULT;
      S_MULT:   if (cnt_q == CNT_W'(N - 1)) state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and result registers; outputs only move on start acceptance or on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      e_q       <= '0;
      cnt_q     <= '0;
      sig_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      product_q <= '0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q   <= bus.a_i;
            b_q   <= bus.b_i;
            nan_q <= 1'b0;
            inf_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
          end
        end
        S_UNPACK: begin
          sign_q <= res_sign;
          e_q    <= $signed({2'b00, a_q[W-2:MAN_W]}) + $signed({2'b00, b_q[W-2:MAN_W]}) - BIAS_E;
          cnt_q  <= '0;
          if (spec_hit) begin
            product_q <= spec_prod;
            nan_q     <= spec_nan;
            inf_q     <= spec_inf;
          end
        end
        S_MULT: cnt_q <= cnt_q + CNT_W'(1);
        S_NORM: begin
          sig_q    <= norm_v[2*M-2:M-1];
          guard_q  <= norm_v[M-2];
          sticky_q <= (|norm_v[M-3:0]) | lost_v;
          e_q      <= e_q + $signed({{(EW-1){1'b0}}, prod[2*M-1]});
        end
        S_ROUND: begin
          if (rnd_e >= E_MAX) begin
            product_q <= {sign_q, INF_MAG[W-2:0]};
            ovf_q     <= 1'b1;
            inf_q     <= 1'b1;
          end else if (rnd_e <= E_ZERO) begin
            product_q <= {sign_q, {(W-1){1'b0}}};
            unf_q     <= 1'b1;
          end else begin
            product_q <= {sign_q, rnd_e[EXP_W-1:0], rnd_frac};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.product_o   = product_q;
  assign bus.nan_o       = nan_q;
  assign bus.inf_o       = inf_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;

endmodule

// File: tb/tb_fp_multiplier_iter.sv
// Directed bench for the iterative FP multiplier: results, flags, latency, start-while-busy and async reset.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_fp_multiplier_iter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_multiplier_iter_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_multiplier_iter #(
    .EXP_W        (8),
    .MAN_W        (23),
    .BITS_PER_CYC (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flags packed as {nan, inf, overflow, underflow}
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic [3:0] exp_f, input int exp_lat);
    int  lat;
    bit  seen;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_product"}, 64'(bus.product_o), 64'(exp_p));
    check({tag, "_flags"}, 64'({bus.nan_o, bus.inf_o, bus.overflow_o, bus.underflow_o}), 64'(exp_f));
    @(posedge clk);
    #1;
    check({tag, "_idle"}, 64'({bus.busy_o, bus.done_o}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int changes;
    int seen_done;
    logic [31:0] ref_p;
    logic [31:0] exp_rne;

    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    #12;
    check("reset_outputs",
          64'({bus.busy_o, bus.done_o, bus.nan_o, bus.inf_o, bus.overflow_o, bus.underflow_o, bus.product_o}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_1p5x2",  32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    run_op("mul_m2x3",   32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 27);
    run_op("nan_in",     32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    run_op("neg_inf",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0100, 1);
    run_op("zero_signed",32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, 1);
    run_op("overflow",   32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0110, 27);
    run_op("underflow",  32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, 27);
`ifdef FPMUL_RNE_EN
    exp_rne = 32'h3FC00002;
`else
    exp_rne = 32'h3FC00001;
`endif
    run_op("rounding",   32'h3F800001, 32'h3FC00000, exp_rne, 4'b0000, 27);

    // start held high with changing operands: the first op completes, the next is taken only from IDLE
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = 32'h3FC00000;
    bus.b_i     = 32'h40000000;
    @(posedge clk);
    #1;
    bus.a_i   = 32'h7FC00000;
    bus.b_i   = 32'h3F800000;
    ref_p     = exp_rne;
    dones     = 0;
    changes   = 0;
    seen_done = 0;
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        dones++;
        if (dones == 1) begin
          check("hold_first_latency", 64'(k), 64'd27);
          check("hold_first_product", 64'(bus.product_o), 64'h40400000);
          ref_p = 32'h40400000;
        end else if (dones == 2) begin
          check("hold_second_latency", 64'(k), 64'd30);
          check("hold_second_product", 64'(bus.product_o), 64'h7FC00000);
          check("hold_second_nan", 64'(bus.nan_o), 64'd1);
          ref_p = 32'h7FC00000;
        end
      end else if (bus.product_o !== ref_p) begin
        changes++;
      end
    end
    bus.start_i = 1'b0;
    check("hold_done_count", 64'(dones), 64'd2);
    check("hold_product_stable", 64'(changes), 64'd0);
    @(posedge clk);
    #1;
    check("hold_idle", 64'({bus.busy_o, bus.done_o}), 64'd0);

    // asynchronous reset in the middle of MULT
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.a_i     = 32'h3FC00000;
    bus.b_i     = 32'h40000000;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          64'({bus.busy_o, bus.done_o, bus.nan_o, bus.inf_o, bus.overflow_o, bus.underflow_o, bus.product_o}),
          64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) seen_done++;
    end
    check("midreset_no_done", 64'(seen_done), 64'd0);

    run_op("after_reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_multiplier_iter.md
Name: fp_multiplier_iter

Overview:
Parametrised IEEE-754-style floating-point multiplier, the next generation of our 32-bit FP multiply block. The significand product is computed by an iterative shift-add datapath, BITS_PER_CYC bits per cycle, trading latency for area. The block runs a start/busy/done handshake. It flags NaN, infinity, overflow and underflow, and clamps results IEEE-style. It sits in the frontend arithmetic cluster and is driven by a controller that issues one operation at a time.

Parameters:
EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
MAN_W, 23, stored fraction width; operand width W = 1+EXP_W+MAN_W.
BITS_PER_CYC, 1, multiplier bits consumed per MULT cycle; must divide MAN_W+1; N = (MAN_W+1)/BITS_PER_CYC.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
start_i  in  1  request; sampled only in IDLE.
a_i  in  W  operand A; captured on accepted start.
b_i  in  W  operand B; captured on accepted start.
busy_o  out  1  high whenever state != IDLE.
done_o  out  1  one-cycle pulse; product_o and flags are valid from this cycle.
product_o  out  W  result; held until the next accepted start.
nan_o  out  1  result is NaN.
inf_o  out  1  result is ±infinity.
overflow_o  out  1  finite inputs overflowed.
underflow_o  out  1  result underflowed and was flushed to zero.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. All outputs go to 0. An in-flight operation is discarded and no done_o is produced.
- States: IDLE, UNPACK, MULT, NORM, ROUND, DONE; encoding is 3 bits.
- IDLE:
  - start_i=1 captures a_i and b_i, clears all flags, and moves to UNPACK (edge 0).
  - start_i is ignored in every other state, including DONE.
- UNPACK: classify each operand and route.
  - Classes: NaN = exp all ones, frac != 0. Inf = exp all ones, frac = 0. Zero = exp = 0; subnormals are flushed to zero.
  - Any NaN, or Inf×Zero: product = canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0), nan_o=1. Go to DONE.
  - Inf×finite-nonzero, or Inf×Inf: product = ±Inf, inf_o=1. Go to DONE.
  - Zero×finite: product = signed zero, no flags. Go to DONE.
  - Otherwise: go to MULT.
  - Result sign is always signA XOR signB, except for the canonical qNaN.
  - Biased exponent is computed as e = ea+eb-BIAS in an (EXP_W+2)-bit signed register.
- MULT:
  - Significands are {1,frac}, MAN_W+1 bits each.
  - Each cycle consumes BITS_PER_CYC multiplier bits into a 2(MAN_W+1)-bit accumulator.
  - Runs exactly N cycles, counted by a cycle counter, then goes to NORM.
- NORM: if the product MSB is 1, shift right by 1 and set e += 1. Extract the fraction, guard bit and sticky bit (OR of all remaining lower bits).
- ROUND:
  - Apply rounding per the optional feature.
  - If rounding carries out of the significand: shift right by 1, e += 1.
  - Then check the exponent range:
    - e >= 2^EXP_W-1: product = ±Inf, overflow_o=1, inf_o=1.
    - e <= 0: product = signed zero, underflow_o=1.
    - Otherwise: pack the result normally.
  - Go to DONE.
- DONE: done_o=1 for this single cycle. Return to IDLE on the next edge; busy_o falls at that same edge.
- Latency, counted in edges after the start-sampling edge, to done_o high:
  - Normal path: N+3 (default 27).
  - Special path: 1.
- The minimum issue interval is latency+2 cycles.
- Outputs change only at the UNPACK/ROUND→DONE transition, or when flags are cleared on an accepted start.

Optional Feature:
Macro FPMUL_RNE_EN.
- Defined: round-to-nearest-even. Increment when guard=1 and (sticky=1 or fraction LSB=1).
- Undefined: truncation (round toward zero). Guard and sticky are ignored; the rounding carry logic is removed.
- The ROUND state and latency are identical in both builds.

Decomposition:
- Package fpmul_pkg holds:
  - fsm state typedef;
  - operand class typedef (NORMAL, ZERO, INF, NAN);
  - BIAS / QNAN / INF constant functions of EXP_W and MAN_W.
- One sub-module, fpmul_sig_iter, contains the shift-add significand multiplier.
  - Ports: clk, rst_n, load, operands, step, product.
  - Sequenced by the top-level FSM.

Test Plan:
1. 0x3FC00000 × 0x40000000 (1.5×2.0) → 0x40400000, no flags, done_o exactly 27 edges after start. -2.0×3.0 (0xC0000000×0x40400000) → 0xC0C00000.
2. 0x7FC00000 × 0x3F800000 → 0x7FC00000, nan_o=1. 0x7F800000 × 0x00000000 → 0x7FC00000, nan_o=1. Both with done_o 1 edge after start.
3. 0x7F000000 × 0x7F000000 → 0x7F800000, overflow_o=1, inf_o=1. 0x00800000 × 0x00800000 → 0x00000000, underflow_o=1.
4. 0x3F800001 × 0x3FC00000 → 0x3FC00002 with FPMUL_RNE_EN, 0x3FC00001 without.
5. start_i held high with new operands throughout an operation → ignored until IDLE. Exactly one done_o per accepted start; product_o stable between done pulses.
6. rst_n pulsed low mid-MULT → all outputs 0 immediately, no done_o. A fresh start afterwards gives the correct result (repeat test 1).
